hazard_control_unit: RTL and testbench

//  Pipeline sequencer for the 5-stage core; sits beside the forwarding logic.

---
 rtl/core_pkg.sv | 27 ++
 rtl/load_use_detector.sv | 18 +
 rtl/hazard_control_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: hazard-sequencer states, the pipeline control bundle
// and register-index width.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MUL_WAIT = 2'd2,
    MEM_WAIT = 2'd3
  } hcu_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic bubble_ex;
    logic bubble_mem;
    logic flush_if;
  } hcu_ctrl_t;

  // Quiescent control: nothing held, nothing zeroed.
  localparam hcu_ctrl_t HCU_CTRL_NOP = hcu_ctrl_t'(7'b000_0000);

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detector #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic                  idex_mem_read_i,
  output logic                  hazard_o
);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    hazard_o = idex_mem_read_i && (idex_rd_i != '0) &&
               ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: turns load-use, multi-cycle MUL, D-cache misses and taken
// branches into per-stage stall / bubble / flush controls.
module hazard_control_unit
  import core_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int REG_ADDR_W  = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] in_IFID_rs1,
  input  logic [REG_ADDR_W-1:0] in_IFID_rs2,
  input  logic [REG_ADDR_W-1:0] in_IDEX_rd,
  input  logic                  in_IDEX_mem_read,
  input  logic                  in_IDEX_is_mul,
  input  logic                  in_EX_branch_taken,
  input  logic                  in_dcache_req,
  input  logic                  in_dcache_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  bubble_ex,
  output logic                  bubble_mem,
  output logic                  flush_if,
  output logic                  busy
);

  localparam int MUL_CNT_W = $clog2(MUL_LATENCY);
  localparam logic [MUL_CNT_W-1:0] MUL_CNT_LOAD = MUL_CNT_W'(MUL_LATENCY - 2);

  hcu_state_t           state_q, state_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic                 mul_done_q, mul_done_d;
  logic                 load_use_s;
  logic                 miss_s;
  logic                 mul_trig_s;
  hcu_ctrl_t            ctrl_s;

  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detector (
    .ifid_rs1_i      (in_IFID_rs1),
    .ifid_rs2_i      (in_IFID_rs2),
    .idex_rd_i       (in_IDEX_rd),
    .idex_mem_read_i (in_IDEX_mem_read),
    .hazard_o        (load_use_s)
  );

  assign miss_s     = in_dcache_req && !in_dcache_ready;
  // The MUL that just finished is still visible in IDEX until it advances.
  assign mul_trig_s = in_IDEX_is_mul && !mul_done_q;

  // Next-state, MUL countdown and done-flag logic.
  always_comb begin
    state_d    = state_q;
    mul_cnt_d  = mul_cnt_q;
    mul_done_d = mul_done_q;
    if (miss_s) begin
      state_d   = MEM_WAIT;
      mul_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          // Nothing is held in RUN, so IDEX advances and the done flag retires.
          mul_done_d = 1'b0;
          if (mul_trig_s) begin
            state_d   = MUL_WAIT;
            mul_cnt_d = MUL_CNT_LOAD;
          end else if (load_use_s && !in_EX_branch_taken) begin
            state_d = LOAD_USE;
          end else begin
            state_d = RUN;
          end
        end
        LOAD_USE: state_d = RUN;
        MUL_WAIT: begin
          if (mul_cnt_q == '0) begin
            state_d    = RUN;
            mul_done_d = 1'b1;
          end else begin
            mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
          end
        end
        MEM_WAIT: state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // State, counter and done-flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      mul_cnt_q  <= '0;
      mul_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_done_q <= mul_done_d;
    end
  end

  // Output decode; a held register never receives a bubble or flush.
  always_comb begin
    ctrl_s = HCU_CTRL_NOP;
    if (reset) begin
      ctrl_s = HCU_CTRL_NOP;
    end else if (miss_s || (state_q == MEM_WAIT)) begin
      ctrl_s.stall_if  = 1'b1;
      ctrl_s.stall_id  = 1'b1;
      ctrl_s.stall_ex  = 1'b1;
      ctrl_s.stall_mem = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (in_EX_branch_taken && !mul_trig_s) begin
            ctrl_s.flush_if  = 1'b1;
            ctrl_s.bubble_ex = 1'b1;
          end else begin
            ctrl_s = HCU_CTRL_NOP;
          end
        end
        LOAD_USE: begin
          ctrl_s.stall_if  = 1'b1;
          ctrl_s.bubble_ex = 1'b1;
        end
        MUL_WAIT: begin
          ctrl_s.stall_if   = 1'b1;
          ctrl_s.stall_id   = 1'b1;
          ctrl_s.bubble_mem = 1'b1;
        end
        default: ctrl_s = HCU_CTRL_NOP;
      endcase
    end
  end

  assign stall_if   = ctrl_s.stall_if;
  assign stall_id   = ctrl_s.stall_id;
  assign stall_ex   = ctrl_s.stall_ex;
  assign stall_mem  = ctrl_s.stall_mem;
  assign bubble_ex  = ctrl_s.bubble_ex;
  assign bubble_mem = ctrl_s.bubble_mem;
  assign flush_if   = ctrl_s.flush_if;
  assign busy       = !reset && (state_q != RUN);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; outputs compared as
// {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, flush_if, busy}.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       mem_read, is_mul, br_taken, dc_req, dc_ready;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       bubble_ex, bubble_mem, flush_if, busy;
  logic [7:0] outs_s;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.MUL_LATENCY(3), .REG_ADDR_W(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_IFID_rs1        (rs1),
    .in_IFID_rs2        (rs2),
    .in_IDEX_rd         (rd),
    .in_IDEX_mem_read   (mem_read),
    .in_IDEX_is_mul     (is_mul),
    .in_EX_branch_taken (br_taken),
    .in_dcache_req      (dc_req),
    .in_dcache_ready    (dc_ready),
    .stall_if           (stall_if),
    .stall_id           (stall_id),
    .stall_ex           (stall_ex),
    .stall_mem          (stall_mem),
    .bubble_ex          (bubble_ex),
    .bubble_mem         (bubble_mem),
    .flush_if           (flush_if),
    .busy               (busy)
  );

  assign outs_s = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, flush_if, busy};

  function automatic logic [20:0] mk(input logic rst, input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] d, input logic mr, input logic mul,
                                     input logic br, input logic req, input logic rdy);
    return {rst, a, b, d, mr, mul, br, req, rdy};
  endfunction

  // Drive one cycle of inputs just after the edge, then let outputs settle.
  task automatic apply(input logic [20:0] s);
    @(posedge clk);
    #1;
    {reset, rs1, rs2, rd, mem_read, is_mul, br_taken, dc_req, dc_ready} = s;
    #2;
  endtask

  task automatic test_reset();
    logic [20:0] st [2];
    logic [7:0]  ex [2];
    st = '{mk(1,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'h00, 8'h00};
    for (int i = 0; i < 2; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [20:0] st [9];
    logic [7:0]  ex [9];
    st = '{mk(0,5,1,5,1,0,0,0,0), mk(0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0),
           mk(0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,0,0,0,0),
           mk(0,1,5,5,1,0,0,0,0), mk(0,0,0,0,0,0,0,0,0),
           mk(0,5,5,5,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'h00, 8'h89, 8'h00, 8'h00, 8'h00, 8'h00, 8'h89, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [20:0] st [5];
    logic [7:0]  ex [5];
    st = '{mk(0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,1,0,0,0),
           mk(0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'h00, 8'hC5, 8'hC5, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL mul[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
    end
  endtask

  task automatic test_cache_miss();
    logic [20:0] st [6];
    logic [7:0]  ex [6];
    st = '{mk(0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,1,0),
           mk(0,0,0,0,0,0,0,1,0), mk(0,0,0,0,0,0,0,1,1), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'hF0, 8'hF1, 8'hF1, 8'hF1, 8'hF1, 8'h00};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL cache_miss[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [20:0] st [7];
    logic [7:0]  ex [7];
    st = '{mk(0,0,0,0,0,0,1,0,0), mk(0,0,0,0,0,0,0,0,0),
           mk(0,0,0,0,0,0,1,1,0), mk(0,0,0,0,0,0,1,1,0), mk(0,0,0,0,0,0,1,1,1),
           mk(0,0,0,0,0,0,1,0,0), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'h0A, 8'h00, 8'hF0, 8'hF1, 8'hF1, 8'h0A, 8'h00};
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
    end
  endtask

  task automatic test_load_use_branch();
    logic [20:0] st [2];
    logic [7:0]  ex [2];
    st = '{mk(0,5,1,5,1,0,1,0,0), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'h0A, 8'h00};
    for (int i = 0; i < 2; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL lu_branch[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] st [4];
    logic [7:0]  ex [4];
    st = '{mk(0,5,1,5,1,0,0,0,0), mk(0,0,0,0,0,0,0,1,0),
           mk(0,0,0,0,0,0,0,1,1), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'h00, 8'hF1, 8'hF1, 8'h00};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
    end
  endtask

  task automatic test_reset_in_mul();
    logic [20:0] st [4];
    logic [7:0]  ex [4];
    st = '{mk(0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,1,0,0,0),
           mk(0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0)};
    ex = '{8'h00, 8'hC5, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      n_checks++;
      if (outs_s !== ex[i]) begin
        n_fail++;
        $display("FAIL reset_in_mul[%0d]: got %b expected %b", i, outs_s, ex[i]);
      end
      // Reset is sampled at the edge closing the first MUL_WAIT cycle (mul_cnt=1).
      if (i == 1) reset = 1'b1;
    end
  endtask

  initial begin
    {reset, rs1, rs2, rd, mem_read, is_mul, br_taken, dc_req, dc_ready} = mk(1,0,0,0,0,0,0,0,0);
    test_reset();
    test_load_use();
    test_mul();
    test_cache_miss();
    test_branch();
    test_load_use_branch();
    test_back_to_back();
    test_reset_in_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
